alu_datapath: RTL and testbench

//  Parametrised register-file + ALU execution unit: accepts one instruction per valid/ready

---
 rtl/alu_datapath.sv | 163 ++++++++++++++++
 tb/tb_alu_datapath.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// alu_datapath: register file plus ALU execution unit.
// Each accepted instruction walks IDLE -> READ -> EXEC -> WB, so one
// instruction completes every four cycles. Because writeback finishes
// before the next source read, no forwarding or hazard logic is needed.
module alu_datapath #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [4+3*ADDR_W-1:0]   instruction,
   output logic                    done,
   output logic [WIDTH-1:0]        result,
   output logic                    flag_zero,
   output logic                    flag_carry,
   output logic                    illegal,
   input  logic [ADDR_W-1:0]       dbg_addr,
   output logic [WIDTH-1:0]        dbg_data
);

   localparam int NREGS = 2**ADDR_W;
   localparam int IW    = 4 + 3*ADDR_W;
   localparam int SH_W  = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    regs [NREGS];

   // Latched instruction fields (stage 0) and source operands (stage 1)
   logic [3:0]          op_p0;
   logic [ADDR_W-1:0]   rd_p0;
   logic [ADDR_W-1:0]   rs1_p0;
   logic [ADDR_W-1:0]   rs2_p0;
   logic [WIDTH-1:0]    a_p1;
   logic [WIDTH-1:0]    b_p1;

   // Incoming instruction fields, MSB first: op, rd, rs1, rs2
   logic [3:0]          op_in;
   logic [ADDR_W-1:0]   rd_in;
   logic [ADDR_W-1:0]   rs1_in;
   logic [ADDR_W-1:0]   rs2_in;

   assign op_in  = instruction[IW-1 -: 4];
   assign rd_in  = instruction[3*ADDR_W-1 -: ADDR_W];
   assign rs1_in = instruction[2*ADDR_W-1 -: ADDR_W];
   assign rs2_in = instruction[ADDR_W-1:0];

   // Immediates: short imm is the rs2 field, long imm is {rs1,rs2}
   logic [WIDTH-1:0]    imm;
   logic [WIDTH-1:0]    limm;
   logic [WIDTH-1:0]    opnd;
   logic [WIDTH:0]      add_w;
   logic [WIDTH:0]      sub_w;

   assign imm   = WIDTH'(rs2_p0);
   assign limm  = WIDTH'({rs1_p0, rs2_p0});
   // Register-register ops are 0..5; everything from 6 up takes the immediate
   assign opnd  = (op_p0 >= 4'd6) ? imm : b_p1;
   // The extra top bit is the carry for add and the borrow (a < b) for subtract
   assign add_w = {1'b0, a_p1} + {1'b0, opnd};
   assign sub_w = {1'b0, a_p1} - {1'b0, opnd};

   logic [WIDTH-1:0]    alu_res;
   logic                alu_carry;
   logic                carry_upd;
   logic                alu_legal;

   // ALU: compute the result and decide which flags this op is allowed to touch
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      carry_upd = 1'b0;
      alu_legal = 1'b1;
      unique case (op_p0)
         4'd0, 4'd9: begin
            alu_res   = add_w[WIDTH-1:0];
            alu_carry = add_w[WIDTH];
            carry_upd = 1'b1;
         end
         4'd1, 4'd10: begin
            alu_res   = sub_w[WIDTH-1:0];
            alu_carry = sub_w[WIDTH];
            carry_upd = 1'b1;
         end
         4'd2:        alu_res[0] = sub_w[WIDTH];
         4'd3, 4'd6:  alu_res = a_p1 & opnd;
         4'd4, 4'd7:  alu_res = a_p1 | opnd;
         4'd5, 4'd8:  alu_res = a_p1 ^ opnd;
         4'd11:       alu_res = a_p1 << opnd[SH_W-1:0];
         4'd12:       alu_res = a_p1 >> opnd[SH_W-1:0];
         4'd13:       alu_res = limm;
         default:     alu_legal = 1'b0;
      endcase
   end

   assign dbg_data = regs[dbg_addr];

   // Sequencer FSM with the register file, operand latches and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         done        <= 1'b0;
         illegal     <= 1'b0;
         result      <= '0;
         flag_zero   <= 1'b0;
         flag_carry  <= 1'b0;
         op_p0       <= '0;
         rd_p0       <= '0;
         rs1_p0      <= '0;
         rs2_p0      <= '0;
         a_p1        <= '0;
         b_p1        <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op_p0       <= op_in;
                  rd_p0       <= rd_in;
                  rs1_p0      <= rs1_in;
                  rs2_p0      <= rs2_in;
                  instr_ready <= 1'b0;
                  state       <= S_READ;
               end
            end
            S_READ: begin
               a_p1  <= regs[rs1_p0];
               b_p1  <= regs[rs2_p0];
               state <= S_EXEC;
            end
            S_EXEC: begin
               // Illegal ops leave result and flags exactly as they were
               if (alu_legal) begin
                  result    <= alu_res;
                  flag_zero <= (alu_res == '0);
                  if (carry_upd) flag_carry <= alu_carry;
               end
               illegal <= ~alu_legal;
               done    <= 1'b1;
               state   <= S_WB;
            end
            S_WB: begin
               if (!illegal) regs[rd_p0] <= result;
               done        <= 1'b0;
               illegal     <= 1'b0;
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_datapath.sv
// Testbench for alu_datapath: directed vector table, reset and
// back-to-back handshake sequences, then random instructions compared
// against an arithmetic reference model of the instruction set.
module tb_alu_datapath;

   localparam int  WIDTH  = 16;
   localparam int  ADDR_W = 4;
   localparam longint MOD = 65536;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [15:0]           instruction;
   logic                  done;
   logic [WIDTH-1:0]      result;
   logic                  flag_zero;
   logic                  flag_carry;
   logic                  illegal;
   logic [ADDR_W-1:0]     dbg_addr;
   logic [WIDTH-1:0]      dbg_data;

   int checks = 0;
   int errors = 0;

   alu_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .done        (done),
      .result      (result),
      .flag_zero   (flag_zero),
      .flag_carry  (flag_carry),
      .illegal     (illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: architectural state only, computed with plain arithmetic
   longint m_regs [16];
   longint m_res;
   bit     m_z, m_c, m_ill;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_res = 0; m_z = 0; m_c = 0; m_ill = 0;
   endtask

   task automatic model_step(input int op, input int rd, input int rs1, input int rs2);
      longint a, b, imm, t;
      a   = m_regs[rs1];
      b   = m_regs[rs2];
      imm = rs2;
      t   = 0;
      m_ill = (op >= 14);
      if (m_ill) return;
      case (op)
         0:  begin t = a + b;   m_c = (t >= MOD); t = t % MOD; end
         1:  begin m_c = (a < b);   t = (a - b + MOD) % MOD; end
         2:  t = (a < b) ? 1 : 0;
         3:  t = a & b;
         4:  t = a | b;
         5:  t = a ^ b;
         6:  t = a & imm;
         7:  t = a | imm;
         8:  t = a ^ imm;
         9:  begin t = a + imm; m_c = (t >= MOD); t = t % MOD; end
         10: begin m_c = (a < imm); t = (a - imm + MOD) % MOD; end
         11: t = (a * (longint'(1) << (imm % 16))) % MOD;
         12: t = a / (longint'(1) << (imm % 16));
         default: t = rs1 * 16 + rs2;
      endcase
      m_res = t;
      m_z   = (t == 0);
      m_regs[rd] = t;
   endtask

   // Full handshake for one instruction, checking every state along the way
   task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                            input longint e_res, input bit e_z, input bit e_c,
                            input bit e_ill, input longint e_rd);
      @(negedge clk);
      chk("ready_before_accept", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instruction = {4'(op), 4'(rd), 4'(rs1), 4'(rs2)};
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instruction = 16'($urandom);
      chk("ready_in_read", 32'(instr_ready), 32'd0);
      chk("done_in_read", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("done_in_exec", 32'(done), 32'd0);
      chk("illegal_in_exec", 32'(illegal), 32'd0);
      @(posedge clk); #1;
      chk("done_in_wb", 32'(done), 32'd1);
      chk("illegal_in_wb", 32'(illegal), 32'(e_ill));
      chk("result", 32'(result), 32'(e_res));
      chk("flag_zero", 32'(flag_zero), 32'(e_z));
      chk("flag_carry", 32'(flag_carry), 32'(e_c));
      @(posedge clk); #1;
      chk("done_after_wb", 32'(done), 32'd0);
      chk("illegal_after_wb", 32'(illegal), 32'd0);
      chk("ready_after_wb", 32'(instr_ready), 32'd1);
      dbg_addr = 4'(rd);
      #1;
      chk("dbg_rd", 32'(dbg_data), 32'(e_rd));
   endtask

   typedef struct {
      int     op, rd, rs1, rs2;
      longint res;
      bit     z, c, ill;
   } vec_t;

   vec_t tbl [20];

   initial begin
      int dcnt;
      int op, rd, rs1, rs2;

      tbl[0]  = '{13,  3,  0,  5, 'h0005, 0, 0, 0};  // LI r3,5
      tbl[1]  = '{13,  7,  0,  1, 'h0001, 0, 0, 0};  // LI r7,1
      tbl[2]  = '{ 0,  3,  7,  3, 'h0006, 0, 0, 0};  // ADD r3=r7+r3
      tbl[3]  = '{13,  1, 15, 15, 'h00FF, 0, 0, 0};  // LI r1,0xFF
      tbl[4]  = '{11,  1,  1,  8, 'hFF00, 0, 0, 0};  // SHLI r1,r1,8
      tbl[5]  = '{ 0,  1,  1,  1, 'hFE00, 0, 1, 0};  // ADD r1=r1+r1
      tbl[6]  = '{ 1,  4,  0,  7, 'hFFFF, 0, 1, 0};  // SUB r4=r0-r7
      tbl[7]  = '{ 1,  5,  7,  7, 'h0000, 1, 0, 0};  // SUB r5=r7-r7
      tbl[8]  = '{15,  3,  0,  0, 'h0000, 1, 0, 1};  // illegal, rd=3
      tbl[9]  = '{ 2,  6,  7,  3, 'h0001, 0, 0, 0};  // SLTU r6=r7<r3
      tbl[10] = '{ 8,  6,  6,  1, 'h0000, 1, 0, 0};  // XORI r6,r6,1
      tbl[11] = '{12,  8,  1,  4, 'h0FE0, 0, 0, 0};  // SHRI r8=r1>>4
      tbl[12] = '{14,  8,  0,  0, 'h0FE0, 0, 0, 1};  // illegal, rd=8
      tbl[13] = '{10,  9,  7,  2, 'hFFFF, 0, 1, 0};  // SUBI r9=r7-2
      tbl[14] = '{ 6, 10,  1, 15, 'h0000, 1, 1, 0};  // ANDI r10=r1&15
      tbl[15] = '{ 7, 10, 10,  7, 'h0007, 0, 1, 0};  // ORI r10=r10|7
      tbl[16] = '{ 9, 11,  9,  1, 'h0000, 1, 1, 0};  // ADDI r11=r9+1
      tbl[17] = '{ 3, 12,  1,  9, 'hFE00, 0, 1, 0};  // AND r12=r1&r9
      tbl[18] = '{ 4, 12,  7, 10, 'h0007, 0, 1, 0};  // OR r12=r7|r10
      tbl[19] = '{ 5, 13, 12, 10, 'h0000, 1, 1, 0};  // XOR r13=r12^r10

      reset       = 1'b1;
      instr_valid = 1'b0;
      instruction = '0;
      dbg_addr    = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_zero", 32'(flag_zero), 32'd0);
      chk("rst_carry", 32'(flag_carry), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset asserted while LI r2,9 sits in EXEC
      @(negedge clk);
      instr_valid = 1'b1;
      instruction = {4'd13, 4'd2, 4'd0, 4'd9};
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ready", 32'(instr_ready), 32'd1);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk("midrst_reg", 32'(dbg_data), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ready_next", 32'(instr_ready), 32'd1);
      dcnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      chk("midrst_no_done", 32'(dcnt), 32'd0);
      dbg_addr = 4'd2;
      #1;
      chk("midrst_r2", 32'(dbg_data), 32'd0);

      // Directed vector table
      for (int i = 0; i < 20; i++) begin
         model_step(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
         run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                   tbl[i].res, tbl[i].z, tbl[i].c, tbl[i].ill, m_regs[tbl[i].rd]);
      end
      dbg_addr = 4'd3;
      #1;
      chk("r3_after_illegal", 32'(dbg_data), 32'h6);

      // Valid held high: accepts only on every fourth edge
      @(negedge clk);
      instr_valid = 1'b1;
      instruction = {4'd13, 4'd9, 4'd2, 4'hA};
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         chk("held_ready", 32'(instr_ready), (i % 4 == 0) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         if (done) dcnt++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      chk("held_done_count", 32'(dcnt), 32'd3);
      model_step(13, 9, 2, 10);
      dbg_addr = 4'd9;
      #1;
      chk("held_r9", 32'(dbg_data), 32'h2A);
      chk("held_result", 32'(result), 32'h2A);

      // Random instructions against the reference model
      for (int n = 0; n < 80; n++) begin
         op  = int'($urandom_range(0, 15));
         rd  = int'($urandom_range(0, 15));
         rs1 = int'($urandom_range(0, 15));
         rs2 = int'($urandom_range(0, 15));
         model_step(op, rd, rs1, rs2);
         run_instr(op, rd, rs1, rs2, m_res, m_z, m_c, m_ill, m_regs[rd]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
